motoro3_speed_sequencer: RTL and testbench

MOTORO3_SPEED_SEQUENCER -- requirements
Module: motoro3_speed_sequencer

---
 rtl/motoro3_pkg.sv | 29 ++
 rtl/motoro3_step_timer.sv | 47 ++++
 rtl/motoro3_speed_sequencer.sv | 175 +++++++++++++++++
 tb/tb_motoro3_speed_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/motoro3_pkg.sv
// Shared encodings for the motoro3 speed sequencer: FSM states, m3step codes,
// period width and the commutation-order helper.
package motoro3_pkg;

   localparam int PERIOD_W = 25;
   typedef logic [PERIOD_W-1:0] period_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_RAMP  = 3'd2,
      ST_RUN   = 3'd3,
      ST_BRAKE = 3'd4
   } seq_state_t;

   localparam logic [3:0] M3_IDLE      = 4'd0;
   localparam logic [3:0] M3_BRAKE     = 4'd7;
   localparam logic [3:0] M3_FIRST_FWD = 4'd1;
   localparam logic [3:0] M3_FIRST_REV = 4'd6;

   // Next commutation step: 1..6 forward, 6..1 reverse, wrapping at the ends.
   function automatic logic [3:0] next_step(input logic [3:0] step, input logic rev);
      if (rev)
         return (step <= 4'd1) ? 4'd6 : step - 4'd1;
      else
         return (step >= 4'd6) ? 4'd1 : step + 4'd1;
   endfunction

endpackage

// File: rtl/motoro3_step_timer.sv
// Commutation step timer: down-counter with reload, owns the m3step register
// and the step_tick pulse. All state updates on the falling clock edge.
module motoro3_step_timer
   import motoro3_pkg::*;
(
   input  logic       clk,
   input  logic       nRst,
   input  logic       set_step,
   input  logic [3:0] step_val,
   input  logic       load,
   input  logic       run,
   input  logic       rev,
   input  period_t    reload,
   output logic [3:0] m3step,
   output logic       step_tick,
   output logic       adv_now
);

   period_t cnt;

   // High in the cycle whose falling edge advances the step.
   assign adv_now = run && (cnt == '0);

   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt       <= '0;
         m3step    <= M3_IDLE;
         step_tick <= 1'b0;
      end else begin
         step_tick <= 1'b0;
         if (set_step) begin
            m3step    <= step_val;
            step_tick <= (step_val != m3step);
            cnt       <= '0;
         end else if (load) begin
            cnt <= reload - period_t'(1);
         end else if (adv_now) begin
            m3step    <= next_step(m3step, rev);
            step_tick <= 1'b1;
            cnt       <= reload - period_t'(1);
         end else if (run) begin
            cnt <= cnt - period_t'(1);
         end
      end
   end

endmodule

// File: rtl/motoro3_speed_sequencer.sv
// BLDC speed sequencer: align, ramp the step period down per electrical round,
// run at target, force-stop brake. Optional round counter under MOTORO3_ROUND_CNT_EN.
module motoro3_speed_sequencer
   import motoro3_pkg::*;
#(
   parameter period_t START_PERIOD = 25'd1_666_667,
   parameter period_t MIN_PERIOD   = 25'd1_667,
   parameter period_t ALIGN_CYCLES = 25'd5_000_000,
   parameter period_t BRAKE_CYCLES = 25'd2_000_000
)(
   input  logic        clk,
   input  logic        nRst,
   input  logic        start,
   input  logic        stop,
   input  logic        dir,
   input  logic [24:0] target_period,
   input  logic [15:0] ramp_step,
   output logic [3:0]  m3step,
   output logic        step_tick,
   output logic [24:0] period_now,
   output logic [2:0]  seq_state,
   output logic        busy,
   output logic        at_speed
`ifdef MOTORO3_ROUND_CNT_EN
   ,output logic [31:0] round_cnt
`endif
);

   seq_state_t state;
   logic       start_q, stop_q, armed;
   logic       dir_q;
   period_t    wait_cnt;
   period_t    eff_tgt;
   period_t    period_nxt;
   logic       start_edge, stop_edge, act_stop;
   logic       align_done, brake_done, run, round_end, adv_now;
   logic       set_step, load;
   logic [3:0] step_val;

   // armed stays low for the first edge after reset so a start held through
   // release is not mistaken for a fresh request.
   assign start_edge = armed & start & ~start_q;
   assign stop_edge  = armed & stop & ~stop_q;
   assign act_stop   = stop_edge &&
                       (state == ST_ALIGN || state == ST_RAMP || state == ST_RUN);
   assign align_done = (state == ST_ALIGN) && (wait_cnt == ALIGN_CYCLES - period_t'(1)) && !act_stop;
   assign brake_done = (state == ST_BRAKE) && (wait_cnt == BRAKE_CYCLES - period_t'(1));
   assign run        = (state == ST_RAMP || state == ST_RUN) && !act_stop;
   assign eff_tgt    = (target_period < MIN_PERIOD) ? MIN_PERIOD : target_period;
   assign round_end  = adv_now && (m3step == (dir_q ? 4'd1 : 4'd6));
   assign load       = align_done;

   always_comb begin
      set_step = 1'b0;
      step_val = m3step;
      if (state == ST_IDLE && start_edge) begin
         set_step = 1'b1;
         step_val = dir ? M3_FIRST_REV : M3_FIRST_FWD;
      end else if (act_stop) begin
         set_step = 1'b1;
         step_val = M3_BRAKE;
      end else if (brake_done) begin
         set_step = 1'b1;
         step_val = M3_IDLE;
      end
   end

   // Ramp arithmetic saturates at the effective target and never wraps.
   always_comb begin
      period_nxt = period_now;
      if (align_done) begin
         period_nxt = (eff_tgt >= START_PERIOD) ? eff_tgt : START_PERIOD;
      end else if (brake_done) begin
         period_nxt = START_PERIOD;
      end else if (run && state == ST_RAMP && round_end) begin
         if (eff_tgt >= period_now)
            period_nxt = eff_tgt;
         else if (period_t'(ramp_step) >= (period_now - eff_tgt))
            period_nxt = eff_tgt;
         else
            period_nxt = period_now - period_t'(ramp_step);
      end else if (run && state == ST_RUN && eff_tgt > period_now) begin
         period_nxt = eff_tgt;
      end
   end

   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst) begin
         state      <= ST_IDLE;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         armed      <= 1'b0;
         dir_q      <= 1'b0;
         wait_cnt   <= '0;
         period_now <= START_PERIOD;
      end else begin
         armed      <= 1'b1;
         start_q    <= start;
         stop_q     <= stop;
         period_now <= period_nxt;
         case (state)
            ST_IDLE: begin
               if (start_edge) begin
                  dir_q    <= dir;
                  wait_cnt <= '0;
                  state    <= ST_ALIGN;
               end
            end
            ST_ALIGN: begin
               if (act_stop) begin
                  wait_cnt <= '0;
                  state    <= ST_BRAKE;
               end else if (align_done) begin
                  state <= (eff_tgt >= START_PERIOD) ? ST_RUN : ST_RAMP;
               end else begin
                  wait_cnt <= wait_cnt + period_t'(1);
               end
            end
            ST_RAMP: begin
               if (act_stop) begin
                  wait_cnt <= '0;
                  state    <= ST_BRAKE;
               end else if (round_end && period_nxt == eff_tgt) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (act_stop) begin
                  wait_cnt <= '0;
                  state    <= ST_BRAKE;
               end else if (eff_tgt < period_now) begin
                  state <= ST_RAMP;
               end
            end
            ST_BRAKE: begin
               if (brake_done)
                  state <= ST_IDLE;
               else
                  wait_cnt <= wait_cnt + period_t'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MOTORO3_ROUND_CNT_EN
   always_ff @(negedge clk or negedge nRst) begin
      if (!nRst)
         round_cnt <= '0;
      else if (state == ST_IDLE || brake_done)
         round_cnt <= '0;
      else if (run && round_end && round_cnt != 32'hFFFF_FFFF)
         round_cnt <= round_cnt + 32'd1;
   end
`endif

   motoro3_step_timer u_step_timer (
      .clk       (clk),
      .nRst      (nRst),
      .set_step  (set_step),
      .step_val  (step_val),
      .load      (load),
      .run       (run),
      .rev       (dir_q),
      .reload    (period_nxt),
      .m3step    (m3step),
      .step_tick (step_tick),
      .adv_now   (adv_now)
   );

   assign seq_state = state;
   assign busy      = (state != ST_IDLE);
   assign at_speed  = (state == ST_RUN);

endmodule

// File: tb/tb_motoro3_speed_sequencer.sv
// Directed bench for motoro3_speed_sequencer with small timing parameters;
// DUT updates on the falling edge, the bench drives and samples on the rising edge.
module tb_motoro3_speed_sequencer;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        dir = 1'b0;
   logic [24:0] target_period = 25'd40;
   logic [15:0] ramp_step = 16'd20;
   logic [3:0]  m3step;
   logic        step_tick;
   logic [24:0] period_now;
   logic [2:0]  seq_state;
   logic        busy;
   logic        at_speed;
`ifdef MOTORO3_ROUND_CNT_EN
   logic [31:0] round_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   motoro3_speed_sequencer #(
      .START_PERIOD (25'd100),
      .MIN_PERIOD   (25'd10),
      .ALIGN_CYCLES (25'd20),
      .BRAKE_CYCLES (25'd15)
   ) dut (
      .clk           (clk),
      .nRst          (nRst),
      .start         (start),
      .stop          (stop),
      .dir           (dir),
      .target_period (target_period),
      .ramp_step     (ramp_step),
      .m3step        (m3step),
      .step_tick     (step_tick),
      .period_now    (period_now),
      .seq_state     (seq_state),
      .busy          (busy),
      .at_speed      (at_speed)
`ifdef MOTORO3_ROUND_CNT_EN
      ,.round_cnt    (round_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Counts rising edges until step_tick is seen, bounded by limit.
   task automatic wait_tick(input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (step_tick !== 1'b1 && n < limit);
      if (step_tick !== 1'b1) check_eq("tick_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_pulse();
      start = 1'b1;
      @(posedge clk);
      start = 1'b0;
   endtask

   task automatic stop_and_brake(input string tag);
      stop = 1'b1;
      @(posedge clk);
      stop = 1'b0;
      check_eq({tag, "_m3_brake"}, m3step, 4'd7);
      check_eq({tag, "_tick_brake"}, step_tick, 1'b1);
      check_eq({tag, "_st_brake"}, seq_state, 3'd4);
      repeat (14) @(posedge clk);
      check_eq({tag, "_st_brake_end"}, seq_state, 3'd4);
      @(posedge clk);
      check_eq({tag, "_st_idle"}, seq_state, 3'd0);
      check_eq({tag, "_m3_idle"}, m3step, 4'd0);
      check_eq({tag, "_busy"}, busy, 1'b0);
      check_eq({tag, "_tick_idle"}, step_tick, 1'b1);
`ifdef MOTORO3_ROUND_CNT_EN
      check_eq({tag, "_round_cnt_clr"}, round_cnt, 32'd0);
`endif
   endtask

   initial begin
      int n;
      logic [3:0]  exp_step;
      logic [24:0] per;

      // reset values
      repeat (3) @(posedge clk);
      check_eq("rst_m3step", m3step, 4'd0);
      check_eq("rst_tick", step_tick, 1'b0);
      check_eq("rst_period", period_now, 25'd100);
      check_eq("rst_state", seq_state, 3'd0);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_at_speed", at_speed, 1'b0);
      nRst = 1'b1;
      repeat (2) @(posedge clk);

      // forward ramp 100 -> 80 -> 60 -> 40
      dir = 1'b0; target_period = 25'd40; ramp_step = 16'd20;
      start_pulse();
      check_eq("fwd_m3_align", m3step, 4'd1);
      check_eq("fwd_tick_align", step_tick, 1'b1);
      check_eq("fwd_st_align", seq_state, 3'd1);
      check_eq("fwd_busy", busy, 1'b1);
      exp_step = 4'd1;
      per = 25'd100;
      for (int r = 0; r < 3; r++) begin
         for (int s = 0; s < 6; s++) begin
            wait_tick(300, n);
            exp_step = (exp_step == 4'd6) ? 4'd1 : exp_step + 4'd1;
            check_eq("fwd_interval", n, (r == 0 && s == 0) ? per + 25'd20 : per);
            check_eq("fwd_step", m3step, exp_step);
         end
         per = per - 25'd20;
         check_eq("fwd_period", period_now, per);
         check_eq("fwd_state", seq_state, (r == 2) ? 3'd3 : 3'd2);
      end
      check_eq("fwd_at_speed", at_speed, 1'b1);
      for (int s = 0; s < 6; s++) begin
         wait_tick(100, n);
         exp_step = (exp_step == 4'd6) ? 4'd1 : exp_step + 4'd1;
         check_eq("run_interval", n, 40);
         check_eq("run_step", m3step, exp_step);
      end
      stop_and_brake("stop");

      // reverse, target above start period: direct RUN at 200
      dir = 1'b1; target_period = 25'd200;
      start_pulse();
      check_eq("rev_m3_align", m3step, 4'd6);
      check_eq("rev_st_align", seq_state, 3'd1);
      repeat (20) @(posedge clk);
      check_eq("rev_st_run", seq_state, 3'd3);
      check_eq("rev_period", period_now, 25'd200);
      check_eq("rev_at_speed", at_speed, 1'b1);
      dir = 1'b0;
      exp_step = 4'd6;
      for (int s = 0; s < 6; s++) begin
         wait_tick(400, n);
         exp_step = (exp_step == 4'd1) ? 4'd6 : exp_step - 4'd1;
         check_eq("rev_interval", n, 200);
         check_eq("rev_step", m3step, exp_step);
      end

      // start and stop on the same clock in RUN
      start = 1'b1; stop = 1'b1;
      @(posedge clk);
      start = 1'b0; stop = 1'b0;
      check_eq("both_m3", m3step, 4'd7);
      check_eq("both_state", seq_state, 3'd4);
      repeat (15) @(posedge clk);
      check_eq("both_idle", seq_state, 3'd0);

      // target 3 clamps to 10; oversized ramp_step saturates; start in RAMP ignored
      dir = 1'b0; target_period = 25'd3; ramp_step = 16'd200;
      start_pulse();
      check_eq("clamp_m3_align", m3step, 4'd1);
      repeat (20) @(posedge clk);
      check_eq("clamp_st_ramp", seq_state, 3'd2);
      check_eq("clamp_period_start", period_now, 25'd100);
      start_pulse();
      check_eq("ramp_start_ign_st", seq_state, 3'd2);
      check_eq("ramp_start_ign_m3", m3step, 4'd1);
      for (int s = 0; s < 6; s++) begin
         wait_tick(300, n);
         check_eq("clamp_interval", n, (s == 0) ? 99 : 100);
      end
      check_eq("clamp_period", period_now, 25'd10);
      check_eq("clamp_state", seq_state, 3'd3);
      check_eq("clamp_step", m3step, 4'd1);
      wait_tick(50, n);
      check_eq("clamp_run_interval", n, 10);
      check_eq("clamp_run_step", m3step, 4'd2);
      stop_and_brake("stop2");

      // ramp_step = 0 holds period 100 for 10 rounds
      target_period = 25'd40; ramp_step = 16'd0;
      start_pulse();
      for (int r = 0; r < 10; r++) begin
         for (int s = 0; s < 6; s++) wait_tick(300, n);
         check_eq("hold_period", period_now, 25'd100);
         check_eq("hold_state", seq_state, 3'd2);
`ifdef MOTORO3_ROUND_CNT_EN
         if (r == 4) check_eq("round_cnt_5", round_cnt, 32'd5);
`endif
      end

      // asynchronous reset mid-RAMP, start held high through release
      #2;
      nRst = 1'b0;
      start = 1'b1;
      #1;
      check_eq("arst_m3step", m3step, 4'd0);
      check_eq("arst_tick", step_tick, 1'b0);
      check_eq("arst_period", period_now, 25'd100);
      check_eq("arst_state", seq_state, 3'd0);
      check_eq("arst_busy", busy, 1'b0);
      check_eq("arst_at_speed", at_speed, 1'b0);
`ifdef MOTORO3_ROUND_CNT_EN
      check_eq("arst_round_cnt", round_cnt, 32'd0);
`endif
      @(posedge clk);
      #1 nRst = 1'b1;
      repeat (6) @(posedge clk);
      check_eq("held_start_state", seq_state, 3'd0);
      check_eq("held_start_m3", m3step, 4'd0);
      check_eq("held_start_busy", busy, 1'b0);
      start = 1'b0;
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
